// File: rtl/dmem_port_arbiter_if.sv
// rtl/dmem_port_arbiter_if.sv - requester, stall and DMEM-side signals of the data-memory port arbiter
// slave = arbiter side, master = requesters plus DMEM instance.
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              m0_req;
  logic              m0_we;
  logic [ADDR_W-1:0] m0_addr;
  logic [DATA_W-1:0] m0_wdata;
  logic              m0_gnt;
  logic [DATA_W-1:0] m0_rdata;
  logic              m0_rvalid;

  logic              m1_req;
  logic              m1_we;
  logic [ADDR_W-1:0] m1_addr;
  logic [DATA_W-1:0] m1_wdata;
  logic              m1_gnt;
  logic [DATA_W-1:0] m1_rdata;
  logic              m1_rvalid;
  logic              m1_lock;

  logic              cpu_stall;

  logic              dmem_wena;
  logic              dmem_rena;
  logic [ADDR_W-1:0] dmem_addr;
  logic [DATA_W-1:0] dmem_wdata;
  logic [DATA_W-1:0] dmem_rdata;

  modport slave (
    input  m0_req, m0_we, m0_addr, m0_wdata,
    output m0_gnt, m0_rdata, m0_rvalid,
    input  m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    output m1_gnt, m1_rdata, m1_rvalid,
    output cpu_stall,
    output dmem_wena, dmem_rena, dmem_addr, dmem_wdata,
    input  dmem_rdata
  );

  modport master (
    output m0_req, m0_we, m0_addr, m0_wdata,
    input  m0_gnt, m0_rdata, m0_rvalid,
    output m1_req, m1_we, m1_addr, m1_wdata, m1_lock,
    input  m1_gnt, m1_rdata, m1_rvalid,
    input  cpu_stall,
    input  dmem_wena, dmem_rena, dmem_addr, dmem_wdata,
    output dmem_rdata
  );
endinterface

// File: rtl/dmem_port_arbiter.sv
// rtl/dmem_port_arbiter.sv - shares single-port DMEM between CPU (M0) and loader/debug DMA (M1)
// Fixed priority (M0 wins ties) by default; define DMEM_ARB_RR_EN for round-robin tie breaking.
module dmem_port_arbiter #(
  parameter int ADDR_W   = 32,
  parameter int DATA_W   = 32,
  parameter int MAX_HOLD = 8
) (
  input  logic               clk,
  input  logic               rst,
  dmem_port_arbiter_if.slave bus
);

  localparam int HOLD_W = (MAX_HOLD <= 2) ? 1 : $clog2(MAX_HOLD);
  localparam logic [HOLD_W-1:0] HOLD_MAX = HOLD_W'(MAX_HOLD - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state;
  state_t            state_nxt;
  logic [HOLD_W-1:0] hold_cnt;
  logic [HOLD_W-1:0] hold_nxt;

  logic gnt0;
  logic gnt1;
  logic hold_ok;
  logic tie_to_m0;
  logic keep0;
  logic stay0;
  logic stay1;

  logic [DATA_W-1:0] rdata0_q;
  logic [DATA_W-1:0] rdata1_q;
  logic              rvalid0_q;
  logic              rvalid1_q;

  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] wdata_mux;

  assign gnt0    = (state == OWN0) & bus.m0_req;
  assign gnt1    = (state == OWN1) & bus.m1_req;
  assign hold_ok = (hold_cnt < HOLD_MAX);

`ifdef DMEM_ARB_RR_EN
  typedef enum logic {
    LAST_M0 = 1'b0,
    LAST_M1 = 1'b1
  } owner_t;

  owner_t last;

  // A contested M0 always yields: M0 was the last owner, so the tie goes to M1.
  assign tie_to_m0 = (last == LAST_M1);
  assign keep0     = 1'b0;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last <= LAST_M1;
    end else if (gnt0) begin
      last <= LAST_M0;
    end else if (gnt1) begin
      last <= LAST_M1;
    end
  end
`else
  assign tie_to_m0 = 1'b1;
  assign keep0     = 1'b1;
`endif

  // The hold limit overrides both M0 priority and the M1 burst lock.
  assign stay0 = hold_ok & keep0;
  assign stay1 = hold_ok & bus.m1_lock;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      hold_cnt <= '0;
    end else begin
      state    <= state_nxt;
      hold_cnt <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (bus.m0_req && bus.m1_req) begin
          state_nxt = tie_to_m0 ? OWN0 : OWN1;
        end else if (bus.m0_req) begin
          state_nxt = OWN0;
        end else if (bus.m1_req) begin
          state_nxt = OWN1;
        end
      end
      OWN0: begin
        if (!bus.m0_req) begin
          state_nxt = bus.m1_req ? OWN1 : IDLE;
        end else if (bus.m1_req && !stay0) begin
          state_nxt = OWN1;
        end
      end
      OWN1: begin
        if (!bus.m1_req) begin
          state_nxt = bus.m0_req ? OWN0 : IDLE;
        end else if (bus.m0_req && !stay1) begin
          state_nxt = OWN0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    hold_nxt = hold_cnt;
    if (state_nxt != state) begin
      hold_nxt = '0;
    end else if ((gnt0 || gnt1) && hold_ok) begin
      hold_nxt = hold_cnt + 1'b1;
    end
  end

  always_comb begin
    addr_mux  = '0;
    wdata_mux = '0;
    if (gnt0) begin
      addr_mux  = bus.m0_addr;
      wdata_mux = bus.m0_wdata;
    end else if (gnt1) begin
      addr_mux  = bus.m1_addr;
      wdata_mux = bus.m1_wdata;
    end
  end

  assign bus.dmem_wena  = (gnt0 & bus.m0_we) | (gnt1 & bus.m1_we);
  assign bus.dmem_rena  = (gnt0 & ~bus.m0_we) | (gnt1 & ~bus.m1_we);
  assign bus.dmem_addr  = addr_mux;
  assign bus.dmem_wdata = wdata_mux;

  // DMEM read data is combinational from dmem_addr, so it is captured in the grant cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rvalid0_q <= 1'b0;
      rvalid1_q <= 1'b0;
      rdata0_q  <= '0;
      rdata1_q  <= '0;
    end else begin
      rvalid0_q <= gnt0 & ~bus.m0_we;
      rvalid1_q <= gnt1 & ~bus.m1_we;
      if (gnt0 && !bus.m0_we) begin
        rdata0_q <= bus.dmem_rdata;
      end
      if (gnt1 && !bus.m1_we) begin
        rdata1_q <= bus.dmem_rdata;
      end
    end
  end

  assign bus.m0_gnt    = gnt0;
  assign bus.m1_gnt    = gnt1;
  assign bus.m0_rdata  = rdata0_q;
  assign bus.m1_rdata  = rdata1_q;
  assign bus.m0_rvalid = rvalid0_q;
  assign bus.m1_rvalid = rvalid1_q;
  assign bus.cpu_stall = bus.m0_req & ~gnt0;

endmodule

// File: tb/tb_dmem_port_arbiter.sv
// tb/tb_dmem_port_arbiter.sv - directed vector and sequence bench for dmem_port_arbiter
module tb_dmem_port_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_HOLD(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mem [0:255];
  logic        mem_ready = 1'b0;

  assign bus.dmem_rdata = mem[bus.dmem_addr[9:2]];

  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 256; i++) mem[i] <= 32'h0;
      mem[4]    <= 32'hDEADBEEF;
      mem[12]   <= 32'h11111111;
      mem_ready <= 1'b1;
    end else if (bus.dmem_wena) begin
      mem[bus.dmem_addr[9:2]] <= bus.dmem_wdata;
    end
  end

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic drive_zero();
    bus.m0_req = 0; bus.m0_we = 0; bus.m0_addr = 0; bus.m0_wdata = 0;
    bus.m1_req = 0; bus.m1_we = 0; bus.m1_addr = 0; bus.m1_wdata = 0;
    bus.m1_lock = 0;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      drive_zero();
    end
  endtask

  typedef struct {
    logic r0; logic w0; logic [31:0] a0; logic [31:0] d0;
    logic r1; logic w1; logic [31:0] a1; logic [31:0] d1; logic lk;
    logic g0; logic g1; logic st; logic we; logic re; logic [31:0] ad;
    logic v0; logic v1; logic [31:0] rd0; logic [31:0] rd1;
  } vec_t;

  vec_t vecs [11];

  task automatic access(input int port, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, output logic [31:0] rdata, output logic ok);
    logic g;
    g = 1'b0;
    for (int i = 0; i < 16 && !g; i++) begin
      @(negedge clk);
      if (port == 0) begin
        bus.m0_req = 1; bus.m0_we = we; bus.m0_addr = addr; bus.m0_wdata = wdata;
      end else begin
        bus.m1_req = 1; bus.m1_we = we; bus.m1_addr = addr; bus.m1_wdata = wdata;
      end
      #1;
      g = (port == 0) ? bus.m0_gnt : bus.m1_gnt;
    end
    @(negedge clk);
    drive_zero();
    #1;
    rdata = (port == 0) ? bus.m0_rdata : bus.m1_rdata;
    ok = g && (((port == 0) ? bus.m0_rvalid : bus.m1_rvalid) == !we);
  endtask

  initial begin
    int          m0_cnt, m1_first, m0_after, both, first_g0;
    int          done, m1_g_first, m1_g_last, m0_g, consec_ok, stall_bad, m1cnt;
    logic [31:0] rd;
    logic        ok;

    //            r0 w0 a0     d0            r1 w1 a1     d1 lk  g0 g1 st we re ad     v0 v1 rd0           rd1
    vecs[0]  = '{1, 0, 32'h10, 0,           0, 0, 0,     0, 0,  0, 0, 1, 0, 0, 0,     0, 0, 0,            0};
    vecs[1]  = '{1, 0, 32'h10, 0,           0, 0, 0,     0, 0,  1, 0, 0, 0, 1, 32'h10, 0, 0, 0,            0};
    vecs[2]  = '{0, 0, 0,      0,           0, 0, 0,     0, 0,  0, 0, 0, 0, 0, 0,     1, 0, 32'hDEADBEEF, 0};
    vecs[3]  = '{1, 1, 32'h20, 32'hA5A5A5A5, 0, 0, 0,    0, 0,  0, 0, 1, 0, 0, 0,     0, 0, 0,            0};
    vecs[4]  = '{1, 1, 32'h20, 32'hA5A5A5A5, 0, 0, 0,    0, 0,  1, 0, 0, 1, 0, 32'h20, 0, 0, 0,            0};
    vecs[5]  = '{0, 0, 0,      0,           0, 0, 0,     0, 0,  0, 0, 0, 0, 0, 0,     0, 0, 0,            0};
    vecs[6]  = '{0, 0, 0,      0,           1, 0, 32'h20, 0, 0, 0, 0, 0, 0, 0, 0,     0, 0, 0,            0};
    vecs[7]  = '{1, 0, 32'h10, 0,           1, 0, 32'h20, 0, 0, 0, 1, 1, 0, 1, 32'h20, 0, 0, 0,            0};
    vecs[8]  = '{1, 0, 32'h10, 0,           0, 0, 0,     0, 0,  1, 0, 0, 0, 1, 32'h10, 0, 1, 0,            32'hA5A5A5A5};
    vecs[9]  = '{0, 0, 0,      0,           0, 0, 0,     0, 0,  0, 0, 0, 0, 0, 0,     1, 0, 32'hDEADBEEF, 0};
    vecs[10] = '{0, 0, 0,      0,           0, 0, 0,     0, 0,  0, 0, 0, 0, 0, 0,     0, 0, 0,            0};

    rst = 1'b1;
    drive_zero();
    repeat (2) @(negedge clk);
    #1;
    chk("rst_g0", bus.m0_gnt, 0);
    chk("rst_g1", bus.m1_gnt, 0);
    chk("rst_v0", bus.m0_rvalid, 0);
    chk("rst_v1", bus.m1_rvalid, 0);
    chk("rst_rd0", bus.m0_rdata, 0);
    chk("rst_wena", bus.dmem_wena, 0);
    chk("rst_rena", bus.dmem_rena, 0);
    chk("rst_addr", bus.dmem_addr, 0);
    @(negedge clk);
    rst = 1'b0;

    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      bus.m0_req = vecs[i].r0; bus.m0_we = vecs[i].w0; bus.m0_addr = vecs[i].a0; bus.m0_wdata = vecs[i].d0;
      bus.m1_req = vecs[i].r1; bus.m1_we = vecs[i].w1; bus.m1_addr = vecs[i].a1; bus.m1_wdata = vecs[i].d1;
      bus.m1_lock = vecs[i].lk;
      #1;
      chk($sformatf("v%0d_g0", i), bus.m0_gnt, vecs[i].g0);
      chk($sformatf("v%0d_g1", i), bus.m1_gnt, vecs[i].g1);
      chk($sformatf("v%0d_stall", i), bus.cpu_stall, vecs[i].st);
      chk($sformatf("v%0d_wena", i), bus.dmem_wena, vecs[i].we);
      chk($sformatf("v%0d_rena", i), bus.dmem_rena, vecs[i].re);
      chk($sformatf("v%0d_addr", i), bus.dmem_addr, vecs[i].ad);
      chk($sformatf("v%0d_v0", i), bus.m0_rvalid, vecs[i].v0);
      chk($sformatf("v%0d_v1", i), bus.m1_rvalid, vecs[i].v1);
      if (vecs[i].v0) chk($sformatf("v%0d_rd0", i), bus.m0_rdata, vecs[i].rd0);
      if (vecs[i].v1) chk($sformatf("v%0d_rd1", i), bus.m1_rdata, vecs[i].rd1);
    end
    idle(2);

`ifndef DMEM_ARB_RR_EN
    // both requesting from IDLE: M0 first, 8 M0 grants, then one M1 grant
    m0_cnt = 0; m1_first = -1; m0_after = 0; both = 0; first_g0 = -1;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      bus.m0_req = 1; bus.m0_we = 0; bus.m0_addr = 32'h10;
      bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h20; bus.m1_lock = 0;
      #1;
      if (bus.m0_gnt && bus.m1_gnt) both++;
      if (bus.m0_gnt && first_g0 < 0) first_g0 = c;
      if (m1_first >= 0 && c == m1_first + 1) m0_after = bus.m0_gnt;
      if (bus.m1_gnt && m1_first < 0) m1_first = c;
      if (bus.m0_gnt && m1_first < 0) m0_cnt++;
    end
    chk("hold_first_g0", first_g0, 1);
    chk("hold_m0_grants", m0_cnt, 8);
    chk("hold_m1_cycle", m1_first, 9);
    chk("hold_m0_back", m0_after, 1);
    chk("hold_no_both", both, 0);
    idle(3);
`else
    rst = 1'b1;
    idle(2);
    rst = 1'b0;
    both = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      bus.m0_req = 1; bus.m0_addr = 32'h10;
      bus.m1_req = 1; bus.m1_addr = 32'h20;
      #1;
      if (bus.m0_gnt && bus.m1_gnt) both++;
      if (c > 0) begin
        chk($sformatf("rr_c%0d_g0", c), bus.m0_gnt, (c % 2) == 1);
        chk($sformatf("rr_c%0d_g1", c), bus.m1_gnt, (c % 2) == 0);
      end
    end
    chk("rr_no_both", both, 0);
    idle(3);
`endif

    // M1 locked write burst of 4, M0 arrives at cycle 2
    done = 0; m1_g_first = -1; m1_g_last = -1; m0_g = -1; consec_ok = 1; stall_bad = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      bus.m1_req = (done < 4); bus.m1_we = 1; bus.m1_addr = 32'h40 + 4 * done;
      bus.m1_wdata = 32'h100 + done; bus.m1_lock = (done < 3);
      bus.m0_req = (c >= 2) && (m0_g < 0); bus.m0_we = 0; bus.m0_addr = 32'h10;
      #1;
      if (bus.m1_gnt) begin
        if (m1_g_last >= 0 && c != m1_g_last + 1) consec_ok = 0;
        if (m1_g_first < 0) m1_g_first = c;
        m1_g_last = c;
        done++;
      end
      if (bus.m0_gnt && m0_g < 0) m0_g = c;
      if (bus.cpu_stall !== ((c >= 2) && (c <= 4))) stall_bad++;
    end
    chk("burst_first", m1_g_first, 1);
    chk("burst_last", m1_g_last, 4);
    chk("burst_consec", consec_ok, 1);
    chk("burst_m0_gnt", m0_g, 5);
    chk("burst_stall", stall_bad, 0);
    for (int k = 0; k < 4; k++) chk($sformatf("burst_mem%0d", k), mem[16 + k], 32'h100 + k);
    idle(2);

    // M1 lock held 30 cycles with M0 waiting from cycle 1
    m0_g = -1; m1cnt = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      bus.m1_req = 1; bus.m1_we = 0; bus.m1_addr = 32'h80; bus.m1_lock = 1;
      bus.m0_req = (c >= 1) && (m0_g < 0); bus.m0_we = 0; bus.m0_addr = 32'h10;
      #1;
      if (bus.m1_gnt && m0_g < 0) m1cnt++;
      if (bus.m0_gnt && m0_g < 0) m0_g = c;
    end
    chk("lock_m1_grants", m1cnt, 8);
    chk("lock_m0_cycle", m0_g, 9);
    idle(3);

    access(0, 1'b1, 32'h20, 32'h12345678, rd, ok);
    chk("wr_ok", ok, 1);
    idle(1);
    access(1, 1'b0, 32'h20, 0, rd, ok);
    chk("rd_ok", ok, 1);
    chk("rd_data", rd, 32'h12345678);
    idle(2);

    // reset in the middle of a granted write
    @(negedge clk);
    bus.m0_req = 1; bus.m0_we = 1; bus.m0_addr = 32'h30; bus.m0_wdata = 32'hCAFEF00D;
    #1;
    chk("rw_idle_g0", bus.m0_gnt, 0);
    @(negedge clk);
    #1;
    chk("rw_g0", bus.m0_gnt, 1);
    chk("rw_wena", bus.dmem_wena, 1);
    rst = 1'b1;
    #1;
    chk("rw_rst_wena", bus.dmem_wena, 0);
    chk("rw_rst_g0", bus.m0_gnt, 0);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rw_after_g0", bus.m0_gnt, 0);
    chk("rw_after_stall", bus.cpu_stall, 1);
    chk("rw_mem", mem[12], 32'h11111111);
    idle(3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
